wb_column_configurator: RTL and testbench
=========================================

WB_COLUMN_CONFIGURATOR -- requirements
Module: wb_column_configurator

Interface
REQ-001 SHALL have parameters: BASE_ADDR, default 32'h3000_0000, register window base; NUM_COLS, default 4, column count (1..8); FIFO_DEPTH, default 8, data FIFO words (power of 2, 2..16).
REQ-002 SHALL have ports (one clock, wb_clk_i; reset wb_rst_ni asynchronous, active-low):
  wb_clk_i  input  1  fabric/bus clock
  wb_rst_ni  input  1  async active-low reset
  wbs_stb_i  input  1  strobe
  wbs_cyc_i  input  1  cycle
  wbs_we_i  input  1  write enable
  wbs_sel_i  input  4  byte lanes
  wbs_data_i  input  32  write data
  wbs_addr_i  input  32  byte address
  wbs_ack_o  output  1  ack
  wbs_data_o  output  32  read data
  cen  output  1  fabric configuration enable
  cfg_bit_out  output  1  serial config bit, shared by all columns
  shift_out  output  NUM_COLS  per-column shift strobe
  set_out  output  NUM_COLS  per-column set (commit) strobe
  busy  output  1  transfer in progress

Function
REQ-003 SHALL decode registers at BASE_ADDR+0x0 CTRL (W), +0x4 LEN (RW, [15:0]), +0x8 DATA (W), +0xC STATUS (R); other addresses ack, read 0, writes ignored.
REQ-004 SHALL assert wbs_ack_o for exactly one cycle, the cycle after stb&cyc sampled high with ack low; no back-to-back acks; register action occurs on the ack cycle.
REQ-005 CTRL write: [0] START, [1] ABORT, [2] CEN (stored, drives cen), [10:8] COL target column; START/ABORT self-clear.
REQ-006 DATA write with wbs_sel_i==4'hF pushes the word into the FIFO; partial sel or FIFO full: word dropped, ERR set.
REQ-007 LEN write honours byte lanes 0-1; ignored (ERR set) while busy.
REQ-008 STATUS read: [0] busy, [1] full, [2] empty, [3] DONE, [4] ERR, [12:8] FIFO count, rest 0.
REQ-009 FSM states IDLE, LOAD, SHIFT, SET; busy=1 in all but IDLE.
REQ-010 IDLE->LOAD on START when LEN!=0 and COL<NUM_COLS; clears DONE, loads bit counter with LEN; else START ignored, ERR set.
REQ-011 LOAD: if FIFO non-empty, pop word into 32-bit shift register, go SHIFT next cycle; if empty, wait in LOAD, all strobes low.
REQ-012 SHIFT: each cycle drive cfg_bit_out = shift register LSB, shift_out[COL]=1, shift right, decrement counter; after 32 bits of a word with counter!=0 go LOAD; at counter==0 go SET.
REQ-013 SET: set_out[COL]=1 for exactly one cycle, then IDLE, DONE=1; unused bits of the last word discarded.
REQ-014 Latency: START ack at cycle T with FIFO non-empty -> first shift_out at T+2; LEN bits over LEN shift cycles plus one LOAD cycle per word after the first; set_out one cycle after last shift.
REQ-015 Only shift_out[COL]/set_out[COL] may assert; all strobes low outside SHIFT/SET; cfg_bit_out is 0 outside SHIFT.
REQ-016 START while busy: ignored, ERR set; ABORT in any state: FSM to IDLE next cycle, FIFO flushed, no set_out, DONE unchanged.
REQ-017 Simultaneous push and pop: FIFO count unchanged; push to full during same-cycle pop is accepted.
REQ-018 DONE and ERR sticky; cleared only by a CTRL write with [3]=1 (ERR) or a successful START (DONE).

Reset
REQ-019 On wb_rst_ni low, asynchronously: FSM IDLE, FIFO empty, LEN=0, CEN=0, DONE=0, ERR=0, all outputs 0; deassertion synchronous to wb_clk_i.
REQ-020 Reset mid-transfer SHALL abort without a set_out pulse.

Verification
REQ-021 Push 32'hA5A5_0001, LEN=8, START COL=2 -> shift_out[2] 8 cycles, cfg_bit_out 1,0,0,0,0,0,0,0, one set_out[2], DONE=1.
REQ-022 LEN=40, one word pushed, START -> 32 shifts, stall in LOAD (busy=1, strobes low); push second word -> 8 more shifts, set_out.
REQ-023 Push FIFO_DEPTH+1 words -> last dropped, STATUS full=1, ERR=1, count=FIFO_DEPTH.
REQ-024 START with COL=NUM_COLS or LEN=0 -> no strobes, busy=0, ERR=1.
REQ-025 ABORT mid-SHIFT -> IDLE next cycle, empty=1, no set_out; reset asserted mid-SHIFT -> all outputs 0 immediately.

Source files
------------

// File: rtl/wb_column_configurator.sv
// Wishbone-programmed column configurator: a word FIFO feeds a serial
// shifter that clocks config bits into one fabric column, then commits.
module wb_column_configurator #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          NUM_COLS   = 4,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_data_i,
  input  logic [31:0]         wbs_addr_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_data_o,
  output logic                cen,
  output logic                cfg_bit_out,
  output logic [NUM_COLS-1:0] shift_out,
  output logic [NUM_COLS-1:0] set_out,
  output logic                busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_SET
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          r_ack;
  logic [31:0]   w_off;
  logic          w_sel_ctrl;
  logic          w_sel_len;
  logic          w_sel_data;
  logic          w_sel_stat;
  logic          w_wr;
  logic          w_ctrl_wr;
  logic          w_abort;
  logic          w_start_req;
  logic          w_start_ok;
  logic          w_start_bad;
  logic [2:0]    w_col_req;
  logic          w_col_ok;
  logic          w_busy;
  logic          w_data_wr;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_len_wr;
  logic          w_len_bad;
  logic          w_full;
  logic          w_empty;
  logic [31:0]   w_rdata;

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;

  logic [15:0]   r_len;
  logic [15:0]   r_bits;
  logic [4:0]    r_idx;
  logic [31:0]   r_sr;
  logic [2:0]    r_col;
  logic          r_cen;
  logic          r_done;
  logic          r_err;

  assign w_off      = wbs_addr_i - BASE_ADDR;
  assign w_sel_ctrl = (w_off == 32'h0);
  assign w_sel_len  = (w_off == 32'h4);
  assign w_sel_data = (w_off == 32'h8);
  assign w_sel_stat = (w_off == 32'hC);

  // Register side effects happen on the ack cycle, master still holding the bus.
  assign w_wr      = r_ack & wbs_stb_i & wbs_cyc_i & wbs_we_i;
  assign w_ctrl_wr = w_wr & w_sel_ctrl;
  assign w_abort   = w_ctrl_wr & wbs_data_i[1];

  assign w_start_req = w_ctrl_wr & wbs_data_i[0];
  assign w_col_req   = wbs_data_i[10:8];
  assign w_col_ok    = ({29'd0, w_col_req} < 32'(NUM_COLS));
  assign w_busy      = (r_state != S_IDLE);
  assign w_start_ok  = w_start_req & ~w_abort & ~w_busy
                     & (r_len != 16'd0) & w_col_ok;
  assign w_start_bad = w_start_req & ~w_abort & ~w_start_ok;

  assign w_full    = (r_cnt == CW'(FIFO_DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_pop     = (r_state == S_LOAD) & ~w_empty;
  assign w_data_wr = w_wr & w_sel_data;
  assign w_push    = w_data_wr & (wbs_sel_i == 4'hF) & (~w_full | w_pop);
  assign w_drop    = w_data_wr & ~w_push;
  assign w_len_wr  = w_wr & w_sel_len;
  assign w_len_bad = w_len_wr & w_busy;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack <= 1'b0;
    end else begin
      r_ack <= wbs_stb_i & wbs_cyc_i & ~r_ack;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_push) begin
      r_mem[r_wp] <= wbs_data_i;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (w_abort) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    shift_out   = '0;
    set_out     = '0;
    cfg_bit_out = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!w_empty) begin
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_out   = NUM_COLS'(1) << r_col;
        cfg_bit_out = r_sr[0];
        if (r_bits == 16'd1) begin
          w_next = S_SET;
        end else if (r_idx == 5'd31) begin
          w_next = S_LOAD;
        end
      end
      S_SET: begin
        set_out = NUM_COLS'(1) << r_col;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_abort) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_bits <= '0;
      r_idx  <= '0;
      r_sr   <= '0;
      r_col  <= '0;
    end else begin
      if (w_start_ok) begin
        r_bits <= r_len;
        r_col  <= w_col_req;
      end
      if (w_pop) begin
        r_sr  <= r_mem[r_rp];
        r_idx <= '0;
      end else if (r_state == S_SHIFT) begin
        r_sr   <= r_sr >> 1;
        r_idx  <= r_idx + 5'd1;
        r_bits <= r_bits - 16'd1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_len  <= '0;
      r_cen  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_cen <= wbs_data_i[2];
      end
      if (w_len_wr && !w_busy) begin
        if (wbs_sel_i[0]) r_len[7:0]  <= wbs_data_i[7:0];
        if (wbs_sel_i[1]) r_len[15:8] <= wbs_data_i[15:8];
      end
      if (w_start_ok) begin
        r_done <= 1'b0;
      end else if (r_state == S_SET) begin
        r_done <= 1'b1;
      end
      // A new error in the same write that clears ERR still wins.
      if (w_drop || w_len_bad || w_start_bad) begin
        r_err <= 1'b1;
      end else if (w_ctrl_wr && wbs_data_i[3]) begin
        r_err <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (r_ack && !wbs_we_i) begin
      unique case (1'b1)
        w_sel_len:  w_rdata = {16'd0, r_len};
        w_sel_stat: w_rdata = {19'd0, 5'(r_cnt), 3'd0, r_err,
                               r_done, w_empty, w_full, w_busy};
        default:    w_rdata = '0;
      endcase
    end
  end

  assign wbs_ack_o  = r_ack;
  assign wbs_data_o = w_rdata;
  assign cen        = r_cen;
  assign busy       = w_busy;

endmodule

// File: tb/tb_wb_column_configurator.sv
// Randomized bench for wb_column_configurator against a word-queue model
// of the bit stream, FIFO occupancy and sticky flags.
module tb_wb_column_configurator;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam int          NC     = 4;
  localparam int          DEPTH  = 8;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_LEN  = BASE + 32'h4;
  localparam logic [31:0] A_DATA = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stb = 1'b0;
  logic          cyc = 1'b0;
  logic          we = 1'b0;
  logic [3:0]    sel = 4'h0;
  logic [31:0]   wdat = '0;
  logic [31:0]   addr = '0;
  logic          ack;
  logic [31:0]   rdat;
  logic          cen;
  logic          cfg_bit_out;
  logic [NC-1:0] shift_out;
  logic [NC-1:0] set_out;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mq[$];
  logic [15:0] m_len = '0;
  logic        m_err = 1'b0;
  logic        m_done = 1'b0;
  logic        m_active = 1'b0;
  logic        m_cen = 1'b0;
  int          m_col = 0;
  int          m_k = 0;
  logic        m_prev_shift = 1'b0;
  logic        mon_en = 1'b0;

  wb_column_configurator #(
    .BASE_ADDR (BASE),
    .NUM_COLS  (NC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_data_i (wdat),
    .wbs_addr_i (addr),
    .wbs_ack_o  (ack),
    .wbs_data_o (rdat),
    .cen        (cen),
    .cfg_bit_out(cfg_bit_out),
    .shift_out  (shift_out),
    .set_out    (set_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [31:0] mask;
    logic [31:0] wd;
    if (rst_n && mon_en) begin
      mask = m_active ? (32'd1 << m_col) : 32'd0;
      check("busy", 32'(busy), 32'(m_active));
      if (shift_out != '0) begin
        check("shift_sel", 32'(shift_out), mask);
        if (m_k / 32 < mq.size()) begin
          wd = mq[m_k / 32];
          check("cfg_bit", 32'(cfg_bit_out), 32'(wd[m_k % 32]));
        end else begin
          check("shift_no_word", m_k, mq.size() * 32);
        end
        m_k++;
        check("shift_over", 32'(m_k > int'(m_len)), 32'd0);
      end else begin
        check("cfg_quiet", 32'(cfg_bit_out), 32'd0);
      end
      if (set_out != '0) begin
        check("set_sel", 32'(set_out), mask);
        check("set_bits", m_k, 32'(m_len));
        check("set_after_shift", 32'(m_prev_shift), 32'd1);
        repeat ((int'(m_len) + 31) / 32) begin
          if (mq.size() > 0) void'(mq.pop_front());
        end
        m_done   = 1'b1;
        m_active = 1'b0;
      end
      m_prev_shift = (shift_out != '0);
    end
  end

  task automatic wb_xfer(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] r);
    int n = 0;
    stb = 1'b1; cyc = 1'b1; we = w; addr = a; wdat = d; sel = s;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 8);
    if (!ack) check("ack_timeout", 32'(ack), 32'd1);
    r = rdat;
    @(posedge clk); #1;
    check("ack_pulse", 32'(ack), 32'd0);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  function automatic int occ();
    return mq.size() - (m_active ? (m_k + 31) / 32 : 0);
  endfunction

  task automatic push(input logic [31:0] w, input logic [3:0] s);
    logic [31:0] r;
    int o;
    o = occ();
    wb_xfer(1'b1, A_DATA, w, s, r);
    if (s == 4'hF && o < DEPTH) mq.push_back(w);
    else m_err = 1'b1;
  endtask

  task automatic set_len(input logic [15:0] v, input logic [3:0] s);
    logic [31:0] r;
    wb_xfer(1'b1, A_LEN, {16'd0, v}, s, r);
    if (m_active) m_err = 1'b1;
    else begin
      if (s[0]) m_len[7:0]  = v[7:0];
      if (s[1]) m_len[15:8] = v[15:8];
    end
  endtask

  task automatic ctrl(input logic [31:0] d);
    logic [31:0] r;
    int col;
    wb_xfer(1'b1, A_CTRL, d, 4'hF, r);
    col = int'(d[10:8]);
    m_cen = d[2];
    if (d[3]) m_err = 1'b0;
    if (d[1]) begin
      m_active = 1'b0;
      mq.delete();
      m_prev_shift = 1'b0;
    end else if (d[0]) begin
      if (m_active || m_len == 16'd0 || col >= NC) m_err = 1'b1;
      else begin
        m_done = 1'b0; m_active = 1'b1; m_col = col; m_k = 0;
      end
    end
  endtask

  task automatic check_status(input string tag);
    logic [31:0] r;
    logic [31:0] e;
    int o;
    wb_xfer(1'b0, A_STAT, 32'd0, 4'hF, r);
    o = occ();
    e = {19'd0, 5'(o), 3'd0, m_err, m_done, o == 0, o == DEPTH, m_active};
    check(tag, r, e);
    check("cen", 32'(cen), 32'(m_cen));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] cw(input int col, input logic c,
                                     input logic [2:0] op);
    return {21'd0, 3'(col), 4'd0, 1'b0, c, op[1:0]} | {29'd0, op[2], 2'd0};
  endfunction

  initial begin
    logic [31:0] r;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_shift", 32'(shift_out), 32'd0);
    check("rst_set", 32'(set_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cen", 32'(cen), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    check_status("reset_status");

    push(32'hA5A5_0001, 4'hF);
    set_len(16'd8, 4'h3);
    ctrl(32'h0000_0205);
    check("lat_load", 32'(shift_out), 32'd0);
    @(posedge clk); #1;
    check("lat_first", 32'(shift_out), 32'd4);
    wait_idle(50);
    check_status("single_word");

    push(32'h1234_5678, 4'hF);
    set_len(16'd40, 4'h3);
    ctrl(32'h0000_0105);
    repeat (40) @(posedge clk);
    #1;
    check("stall_strobe", {shift_out, set_out}, 32'd0);
    check_status("stall_status");
    set_len(16'd5, 4'h3);
    ctrl(32'h0000_0005);
    check_status("busy_errs");
    push(32'h8000_00F3, 4'hF);
    wait_idle(60);
    check_status("two_words");
    ctrl(32'h0000_000C);
    check_status("err_clear");

    for (int i = 0; i < DEPTH + 1; i++) push($urandom, 4'hF);
    check_status("overflow");
    ctrl(32'h0000_0006);
    check_status("flush");

    set_len(16'd16, 4'h3);
    push(32'hFFFF_FFFF, 4'hF);
    ctrl(cw(NC, 1'b1, 3'b001));
    repeat (4) @(posedge clk);
    #1;
    check_status("bad_col");
    set_len(16'd0, 4'h3);
    ctrl(cw(0, 1'b1, 3'b001));
    check_status("zero_len");
    ctrl(cw(0, 1'b1, 3'b110));

    push($urandom, 4'hF);
    push($urandom, 4'hF);
    set_len(16'd64, 4'h3);
    ctrl(cw(3, 1'b1, 3'b001));
    repeat (5) @(posedge clk);
    #1;
    ctrl(cw(3, 1'b1, 3'b010));
    check("abort_shift", 32'(shift_out), 32'd0);
    check_status("abort_status");

    push($urandom, 4'hF);
    set_len(16'd20, 4'h3);
    ctrl(cw(1, 1'b1, 3'b001));
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", {busy, cen, cfg_bit_out, ack, shift_out, set_out},
          32'd0);
    mq.delete();
    m_len = '0; m_err = 1'b0; m_done = 1'b0; m_active = 1'b0;
    m_cen = 1'b0; m_prev_shift = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_status("post_reset");

    for (int it = 0; it < 25; it++) begin
      int nw;
      int col;
      logic cb;
      nw = $urandom_range(0, DEPTH + 1);
      cb = 1'($urandom_range(0, 1));
      for (int j = 0; j < nw; j++) begin
        push($urandom, ($urandom_range(0, 7) == 0) ?
             4'($urandom_range(0, 14)) : 4'hF);
      end
      if ($urandom_range(0, 3) == 0) ctrl(cw(0, cb, 3'b100));
      set_len(16'($urandom_range(0, 32 * mq.size() + 8)),
              ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h3);
      col = $urandom_range(0, NC);
      ctrl(cw(col, cb, 3'b001));
      if (m_active) begin
        if (32 * mq.size() >= int'(m_len)) begin
          wait_idle(int'(m_len) + 32);
        end else begin
          repeat (33 * mq.size() + 4) @(posedge clk);
          #1;
          check_status("rand_stall");
          ctrl(cw(0, cb, 3'b010));
        end
      end
      check_status("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
